// File: rtl/e203_ifu_bht_upd_ctrl.sv
// Arbitrates the single-port BHT counter table between IFU lookups and queued EXU
// branch-resolution updates, each applied as a saturating 2-bit read-modify-write.
module e203_ifu_bht_upd_ctrl #(
    parameter int PC_SIZE    = 32,
    parameter int IDX_W      = 6,
    parameter int QDEPTH     = 4,
    parameter int STARVE_MAX = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wb_vld,
    input  logic [PC_SIZE-1:0] wb_pc,
    input  logic               wb_taken,
    output logic               wb_rdy,
    input  logic               lkp_req,
    input  logic [IDX_W-1:0]   lkp_idx,
    output logic               lkp_gnt,
    input  logic               flush,
    output logic               tbl_cs,
    output logic               tbl_we,
    output logic [IDX_W-1:0]   tbl_addr,
    output logic [1:0]         tbl_wdat,
    input  logic [1:0]         tbl_rdat,
    output logic               busy
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int SW    = $clog2(STARVE_MAX + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             taken;
    } upd_t;

    upd_t             mem_q [QDEPTH];
    upd_t             mem_d [QDEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [1:0]       state_q, state_d;
    logic [SW-1:0]    starve_q, starve_d;

    logic             q_empty;
    logic             q_full;
    logic             push;
    logic             pop;
    logic             starve_max;
    logic             start_rd;
    upd_t             head;
    logic             unused_pc_bits;

    assign unused_pc_bits = ^{wb_pc[PC_SIZE-1:IDX_W+1], wb_pc[0]};

    function automatic logic [1:0] sat_upd(input logic [1:0] c, input logic taken);
        if (taken) begin
            return (c == 2'd3) ? 2'd3 : c + 2'd1;
        end
        return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    // Extra MSB on the pointers distinguishes full from empty when the indices match.
    assign q_empty    = (wr_ptr_q == rd_ptr_q);
    assign q_full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head       = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign push       = wb_vld & ~q_full & ~flush;
    assign pop        = (state_q == ST_WR);
    assign starve_max = (starve_q == SW'(STARVE_MAX));
    // A flush in IDLE holds off the update; the queue is about to be emptied anyway.
    assign start_rd   = (state_q == ST_IDLE) & ~q_empty & ~flush & (~lkp_req | starve_max);

    assign wb_rdy = ~q_full;
    assign busy   = ~q_empty | (state_q != ST_IDLE);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        for (int i = 0; i < QDEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = '{idx: wb_pc[IDX_W:1], taken: wb_taken};
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + (PTR_W + 1)'(push);
            rd_ptr_d = rd_ptr_q + (PTR_W + 1)'(pop);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start_rd) state_d = ST_RD;
            ST_RD:   state_d = flush ? ST_IDLE : ST_WR;
            ST_WR:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (flush || start_rd) begin
            starve_d = '0;
        end else if ((state_q == ST_IDLE) && !q_empty && lkp_req && !starve_max) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // The RMW write uses the read data returned for the RD issued the previous cycle.
    always_comb begin
        lkp_gnt  = 1'b0;
        tbl_cs   = 1'b0;
        tbl_we   = 1'b0;
        tbl_addr = '0;
        tbl_wdat = '0;
        unique case (state_q)
            ST_IDLE: begin
                lkp_gnt  = lkp_req & ~start_rd;
                tbl_cs   = lkp_gnt;
                tbl_addr = lkp_gnt ? lkp_idx : '0;
            end
            ST_RD: begin
                tbl_cs   = 1'b1;
                tbl_addr = head.idx;
            end
            ST_WR: begin
                tbl_cs   = 1'b1;
                tbl_we   = 1'b1;
                tbl_addr = head.idx;
                tbl_wdat = sat_upd(tbl_rdat, head.taken);
            end
            default: begin
                lkp_gnt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            state_q  <= ST_IDLE;
            starve_q <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            state_q  <= state_d;
            starve_q <= starve_d;
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_e203_ifu_bht_upd_ctrl.sv
// Directed bench for the BHT update controller: SRAM model, write scoreboard, immediate assertions.
module tb_e203_ifu_bht_upd_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_vld;
    logic [31:0] wb_pc;
    logic        wb_taken;
    logic        wb_rdy;
    logic        lkp_req;
    logic [5:0]  lkp_idx;
    logic        lkp_gnt;
    logic        flush;
    logic        tbl_cs;
    logic        tbl_we;
    logic [5:0]  tbl_addr;
    logic [1:0]  tbl_wdat;
    logic [1:0]  tbl_rdat;
    logic        busy;

    always #5 clk = ~clk;

    e203_ifu_bht_upd_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_vld   (wb_vld),
        .wb_pc    (wb_pc),
        .wb_taken (wb_taken),
        .wb_rdy   (wb_rdy),
        .lkp_req  (lkp_req),
        .lkp_idx  (lkp_idx),
        .lkp_gnt  (lkp_gnt),
        .flush    (flush),
        .tbl_cs   (tbl_cs),
        .tbl_we   (tbl_we),
        .tbl_addr (tbl_addr),
        .tbl_wdat (tbl_wdat),
        .tbl_rdat (tbl_rdat),
        .busy     (busy)
    );

    typedef struct packed {
        logic [5:0] idx;
        logic [1:0] wdat;
    } wr_t;

    logic [1:0] mem     [64];
    logic [1:0] exp_tbl [64];
    wr_t        sb [$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         n_wr = 0;
    int         w0;

    // Single-port SRAM with one-cycle read latency.
    always @(posedge clk) begin
        if (tbl_cs && !tbl_we) tbl_rdat <= mem[tbl_addr];
        if (tbl_cs && tbl_we) mem[tbl_addr] <= tbl_wdat;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
        if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
        return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    always @(negedge clk) begin : write_mon
        wr_t e;
        if (rst_n && tbl_cs && tbl_we) begin
            n_wr++;
            chk("write_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("write_addr", 32'(tbl_addr), 32'(e.idx));
                chk("write_wdat", 32'(tbl_wdat), 32'(e.wdat));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic push(input int idx, input logic t, input logic acc);
        logic [5:0] i6;
        i6       = idx[5:0];
        wb_vld   = 1'b1;
        wb_pc    = 32'h8000_0000 | (32'(i6) << 1);
        wb_taken = t;
        if (acc) begin
            sb.push_back('{idx: i6, wdat: sat(exp_tbl[i6], t)});
            exp_tbl[i6] = sat(exp_tbl[i6], t);
        end
    endtask

    task automatic resync();
        sb.delete();
        for (int i = 0; i < 64; i++) exp_tbl[i] = mem[i];
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget && (busy || sb.size() != 0); i++) cyc();
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 2'd0;
        mem[10] = 2'd1; mem[20] = 2'd3; mem[21] = 2'd0; mem[22] = 2'd2;
        mem[30] = 2'd1; mem[40] = 2'd2; mem[41] = 2'd2; mem[42] = 2'd2;
        mem[43] = 2'd2; mem[44] = 2'd2; mem[50] = 2'd1; mem[51] = 2'd1;
        mem[52] = 2'd1; mem[60] = 2'd1;
        for (int i = 0; i < 64; i++) exp_tbl[i] = mem[i];
        rst_n = 1'b0; wb_vld = 1'b0; wb_pc = '0; wb_taken = 1'b0;
        lkp_req = 1'b0; lkp_idx = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        smp();
        chk("rst_wb_rdy", 32'(wb_rdy), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cs", 32'(tbl_cs), 32'd0);
        chk("rst_we", 32'(tbl_we), 32'd0);
        chk("rst_gnt", 32'(lkp_gnt), 32'd0);
        chk("rst_addr", 32'(tbl_addr), 32'd0);
        chk("rst_wdat", 32'(tbl_wdat), 32'd0);

        // Idle lookup is granted combinationally
        cyc(); lkp_req = 1'b1; lkp_idx = 6'd5;
        smp();
        chk("lkp_gnt", 32'(lkp_gnt), 32'd1);
        chk("lkp_cs", 32'(tbl_cs), 32'd1);
        chk("lkp_we", 32'(tbl_we), 32'd0);
        chk("lkp_addr", 32'(tbl_addr), 32'd5);
        cyc(); lkp_req = 1'b0;

        // Single update: pc 0x8000_0014 -> idx 10, 1 -> 2
        w0 = n_wr;
        push(10, 1'b1, 1'b1);
        smp(); cyc(); wb_vld = 1'b0;
        smp();
        chk("t2_idle_cs", 32'(tbl_cs), 32'd0);
        chk("t2_busy", 32'(busy), 32'd1);
        cyc(); smp();
        chk("t2_rd_cs", 32'(tbl_cs), 32'd1);
        chk("t2_rd_we", 32'(tbl_we), 32'd0);
        chk("t2_rd_addr", 32'(tbl_addr), 32'd10);
        cyc(); smp();
        chk("t2_wr_we", 32'(tbl_we), 32'd1);
        cyc(); smp();
        chk("t2_busy_after", 32'(busy), 32'd0);
        chk("t2_nwr", 32'(n_wr - w0), 32'd1);

        // Saturation cases
        cyc();
        push(20, 1'b1, 1'b1); cyc();
        push(21, 1'b0, 1'b1); cyc();
        push(22, 1'b0, 1'b0 == 1'b1 ? 1'b0 : 1'b1); cyc();
        wb_vld = 1'b0;
        wait_drain("t3_drain", 40);

        // Starvation: lookups held, update forced after 7 granted cycles
        w0 = n_wr;
        lkp_req = 1'b1; lkp_idx = 6'd7;
        push(30, 1'b0, 1'b1);
        smp();
        chk("t4_gnt_push", 32'(lkp_gnt), 32'd1);
        cyc(); wb_vld = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            smp();
            chk("t4_gnt_granted", 32'(lkp_gnt), 32'd1);
            cyc();
        end
        smp();
        chk("t4_gnt_idle", 32'(lkp_gnt), 32'd0);
        chk("t4_cs_idle", 32'(tbl_cs), 32'd0);
        cyc(); smp();
        chk("t4_gnt_rd", 32'(lkp_gnt), 32'd0);
        chk("t4_rd_addr", 32'(tbl_addr), 32'd30);
        cyc(); smp();
        chk("t4_gnt_wr", 32'(lkp_gnt), 32'd0);
        chk("t4_wr_we", 32'(tbl_we), 32'd1);
        cyc(); smp();
        chk("t4_nwr", 32'(n_wr - w0), 32'd1);
        chk("t4_gnt_after", 32'(lkp_gnt), 32'd1);
        cyc();

        // Backpressure: 4 pushes fill the queue, 5th is dropped
        w0 = n_wr;
        lkp_idx = 6'd3;
        for (int k = 0; k < 4; k++) begin
            push(40 + k, 1'b1, 1'b1);
            smp(); cyc();
        end
        push(44, 1'b1, 1'b0);
        smp();
        chk("t5_wb_rdy_full", 32'(wb_rdy), 32'd0);
        cyc(); wb_vld = 1'b0; lkp_req = 1'b0;
        wait_drain("t5_drain", 60);
        chk("t5_nwr", 32'(n_wr - w0), 32'd4);

        // Flush during RD: no write
        w0 = n_wr;
        push(50, 1'b0, 1'b1);
        smp(); cyc(); wb_vld = 1'b0;
        smp(); cyc(); flush = 1'b1;
        smp();
        chk("t6a_rd_we", 32'(tbl_we), 32'd0);
        chk("t6a_rd_addr", 32'(tbl_addr), 32'd50);
        cyc(); flush = 1'b0; resync();
        smp();
        chk("t6a_busy", 32'(busy), 32'd0);
        repeat (3) cyc();
        chk("t6a_nwr", 32'(n_wr - w0), 32'd0);

        // Flush during WR: in-flight write completes, rest discarded
        w0 = n_wr;
        push(51, 1'b1, 1'b1);
        smp(); cyc();
        push(52, 1'b1, 1'b1);
        smp(); cyc(); wb_vld = 1'b0;
        smp();
        chk("t6b_rd_addr", 32'(tbl_addr), 32'd51);
        cyc(); flush = 1'b1;
        smp();
        chk("t6b_wr_we", 32'(tbl_we), 32'd1);
        cyc(); flush = 1'b0; resync();
        smp();
        chk("t6b_busy", 32'(busy), 32'd0);
        chk("t6b_wb_rdy", 32'(wb_rdy), 32'd1);
        chk("t6b_cs", 32'(tbl_cs), 32'd0);
        repeat (3) cyc();
        chk("t6b_nwr", 32'(n_wr - w0), 32'd1);

        // Flush wins over a same-cycle push
        w0 = n_wr;
        push(53, 1'b1, 1'b0); flush = 1'b1;
        smp(); cyc(); wb_vld = 1'b0; flush = 1'b0;
        smp();
        chk("t6c_busy", 32'(busy), 32'd0);
        repeat (4) cyc();
        chk("t6c_nwr", 32'(n_wr - w0), 32'd0);

        // Reset mid-update abandons the RD
        push(60, 1'b1, 1'b1);
        smp(); cyc(); wb_vld = 1'b0;
        cyc(); rst_n = 1'b0;
        smp();
        chk("t7_busy", 32'(busy), 32'd0);
        chk("t7_cs", 32'(tbl_cs), 32'd0);
        chk("t7_wb_rdy", 32'(wb_rdy), 32'd1);
        cyc(); rst_n = 1'b1; resync();
        repeat (3) cyc();
        chk("t7_busy_after", 32'(busy), 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
